alu_responder: RTL and testbench

Handshaked, registered responder for the 4-bit AND/ADD ALU datapath. It accepts operation requests (operands plus selector) on a valid/ready channel and computes AND or ADD with carry and zero flags. Results are buffered in a small result FIFO and returned on a second valid/ready channel. It is the responding end of the operand-issue interface: the stimulus/controller side issues, this block answers, so the ALU can sit behind flow-controlled logic instead of being driven directly.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_responder_if.sv | 38 +++
 rtl/alu_core.sv | 32 +++
 rtl/alu_responder.sv | 112 +++++++++++
 tb/tb_alu_responder.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit AND/ADD ALU datapath and its responder.
// Holds op encodings, default widths and the packed result layout helper.
// No logic here; imported by the core, the responder and its interface users.
package alu_pkg;

  // Selector encoding
  localparam logic OP_AND = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Default datapath width; the packed result record is {carry, zero, C}
  localparam int DEF_WIDTH = 4;
  localparam int RES_W     = DEF_WIDTH + 2;

  // Width of a packed result record for an arbitrary operand width
  function automatic int res_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/alu_responder_if.sv
// Request/response bundle between an ALU requester and the alu_responder.
// Pure wiring, no latency of its own.
// Both channels are valid/ready; master issues requests and consumes results.
interface alu_responder_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
);

  // Request channel
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             selector;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] C;
  logic             carry;
  logic             zero;

  // Completed-operation counter
  logic [CNT_WIDTH-1:0] op_count;

  // Requester / result consumer side
  modport master (
    output req_valid, A, B, selector, rsp_ready,
    input  req_ready, rsp_valid, C, carry, zero, op_count
  );

  // Responding side (alu_responder)
  modport slave (
    input  req_valid, A, B, selector, rsp_ready,
    output req_ready, rsp_valid, C, carry, zero, op_count
  );

endinterface

// File: rtl/alu_core.sv
// Combinational AND/ADD with carry-out and zero flag.
// Zero latency; purely combinational.
// No handshake; the caller decides when the result is captured.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] c_o,
  output logic             carry_o,
  output logic             zero_o
);

  // One extra bit holds the ADD carry-out
  logic [WIDTH:0] sum;
  assign sum = {1'b0, a_i} + {1'b0, b_i};

  // Select AND or ADD; zero is taken on the truncated result
  always_comb begin
    c_o     = a_i & b_i;
    carry_o = 1'b0;
    if (sel_i == OP_ADD) begin
      c_o     = sum[WIDTH-1:0];
      carry_o = sum[WIDTH];
    end
    zero_o = (c_o == '0);
  end

endmodule

// File: rtl/alu_responder.sv
// Handshaked ALU responder: computes AND/ADD on accept, buffers results in a FIFO.
// Result is visible on the response channel the cycle after its accept edge.
// req_ready drops only when the FIFO is full; it never depends on rsp_ready.
module alu_responder
  import alu_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_responder_if.slave bus
);

  localparam int RW    = res_width(WIDTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Combinational core result for the operands currently presented
  logic [WIDTH-1:0] core_c;
  logic             core_carry;
  logic             core_zero;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i     (bus.A),
    .b_i     (bus.B),
    .sel_i   (bus.selector),
    .c_o     (core_c),
    .carry_o (core_carry),
    .zero_o  (core_zero)
  );

  // FIFO storage and bookkeeping; records packed as {carry, zero, C}
  logic [RW-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] op_cnt_q, op_cnt_d;

  logic          req_ready_w;
  logic          rsp_valid_w;
  logic          acc;
  logic          del;
  logic [RW-1:0] head;

  // Flags come from registered count only, so ready has no path from rsp_ready
  assign req_ready_w = (cnt_q < DEPTH_C);
  assign rsp_valid_w = (cnt_q != '0);
  assign acc         = bus.req_valid && req_ready_w;
  assign del         = bus.rsp_ready && rsp_valid_w;

  // Head entry drives the response payload straight from storage
  assign head          = mem_q[rd_ptr_q];
  assign bus.C         = head[WIDTH-1:0];
  assign bus.zero      = head[WIDTH];
  assign bus.carry     = head[WIDTH+1];
  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = rsp_valid_w;
  assign bus.op_count  = op_cnt_q;

  // Next-state for pointers, occupancy and delivered-op counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    op_cnt_d = op_cnt_q;
    if (acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (del) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      op_cnt_d = op_cnt_q + CNT_WIDTH'(1);
    end
    // Simultaneous accept and deliver leaves occupancy unchanged
    case ({acc, del})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers; reset flushes everything buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  // Result storage: capture the core output at the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (acc) begin
      mem_q[wr_ptr_q] <= {core_carry, core_zero, core_c};
    end
  end

endmodule

// File: tb/tb_alu_responder.sv
module tb_alu_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_responder_if #(.WIDTH(4), .CNT_WIDTH(8)) bus ();

  alu_responder #(
    .WIDTH     (4),
    .DEPTH     (2),
    .CNT_WIDTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int c;
    int carry;
    int zero;
  } res_t;

  // Reference model: queue of pending results plus delivered count
  res_t q[$];
  int   delivered = 0;
  localparam int MDEPTH = 2;

  function automatic res_t ref_op(input int a, input int b, input int sel);
    res_t r;
    int s;
    if (sel != 0) begin
      s       = a + b;
      r.c     = s % 16;
      r.carry = (s >= 16) ? 1 : 0;
    end else begin
      r.c     = a & b;
      r.carry = 0;
    end
    r.zero = (r.c == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, advance both
  task automatic cycle(input int rv, input int a, input int b, input int sel, input int rr);
    bit acc;
    bit del;
    logic [3:0] a4;
    logic [3:0] b4;
    a4 = a[3:0];
    b4 = b[3:0];
    bus.req_valid = rv[0];
    bus.A         = a4;
    bus.B         = b4;
    bus.selector  = sel[0];
    bus.rsp_ready = rr[0];
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(q.size() < MDEPTH));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(q.size() != 0));
    chk("op_count",  32'(bus.op_count),  32'(delivered % 256));
    if (q.size() != 0 && rr != 0) begin
      chk("rsp_C",     32'(bus.C),     32'(q[0].c));
      chk("rsp_carry", 32'(bus.carry), 32'(q[0].carry));
      chk("rsp_zero",  32'(bus.zero),  32'(q[0].zero));
    end
    acc = (rv != 0) && (q.size() < MDEPTH);
    del = (rr != 0) && (q.size() != 0);
    if (del) begin
      void'(q.pop_front());
      delivered++;
    end
    if (acc) q.push_back(ref_op(int'(a4), int'(b4), sel & 1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int rv);
    bus.req_valid = rv[0];
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    q.delete();
    delivered = 0;
  endtask

  // Single accepted op followed by a spec-literal check one cycle later
  task automatic dir(input int a, input int b, input int sel,
                     input int ec, input int ecy, input int ez, input string tag);
    cycle(1, a, b, sel, 1);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_C"},     32'(bus.C),         32'(ec));
    chk({tag, "_carry"}, 32'(bus.carry),     32'(ecy));
    chk({tag, "_zero"},  32'(bus.zero),      32'(ez));
    cycle(0, 0, 0, 0, 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.selector  = 1'b0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    do_reset(0);

    // Reset state
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_op_count",  32'(bus.op_count),  32'd0);

    // Single ops with known answers
    dir(5,  3,  0, 1,  0, 0, "and_5_3");
    dir(5,  3,  1, 8,  0, 0, "add_5_3");
    dir(10, 7,  1, 1,  1, 0, "add_10_7");
    dir(8,  8,  1, 0,  1, 1, "add_8_8");
    dir(8,  0,  0, 0,  0, 1, "and_8_0");
    dir(15, 15, 0, 15, 0, 0, "and_15_15");

    // Backpressure: four requests with consumer stalled, two get in
    do_reset(0);
    for (int i = 0; i < 4; i++)
      cycle(1, $urandom_range(15), $urandom_range(15), $urandom_range(1), 0);
    chk("bp_full_ready", 32'(bus.req_ready), 32'd0);
    chk("bp_full_valid", 32'(bus.rsp_valid), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    chk("bp_op_count", 32'(bus.op_count), 32'd2);

    // Streaming: ten back-to-back ops with consumer always ready
    do_reset(0);
    for (int i = 0; i < 10; i++)
      cycle(1, $urandom_range(15), $urandom_range(15), $urandom_range(1), 1);
    cycle(0, 0, 0, 0, 1);
    chk("stream_op_count", 32'(bus.op_count), 32'd10);

    // Reset while full flushes buffered results; reset beats a pending request
    do_reset(0);
    cycle(1, $urandom_range(15), $urandom_range(15), $urandom_range(1), 0);
    cycle(1, $urandom_range(15), $urandom_range(15), $urandom_range(1), 0);
    chk("prefull_ready", 32'(bus.req_ready), 32'd0);
    do_reset(1);
    chk("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("flush_req_ready", 32'(bus.req_ready), 32'd1);
    chk("flush_op_count",  32'(bus.op_count),  32'd0);
    dir(7, 7, 1, 14, 0, 0, "post_rst_add_7_7");

    // Random traffic with random stalls on both sides
    do_reset(0);
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(3) != 0) ? 1 : 0, $urandom_range(15), $urandom_range(15),
            $urandom_range(1), ($urandom_range(2) != 0) ? 1 : 0);

    // Long stream drives op_count across its wrap point
    for (int i = 0; i < 300; i++)
      cycle(1, $urandom_range(15), $urandom_range(15), $urandom_range(1), 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
